muldiv_iter: RTL and testbench

// Iterative RV32M multiply/divide unit, directly downstream of the ALU operand-2 select mux.
// - operand_b takes the selected operand-2 value from that mux; operand_a comes from register-file port 1.
// - Executes all eight M-extension ops: one radix-2 step per cycle, fixed latency.
// - Control holds the instruction in decode until done is seen, or flushes it.

---
 rtl/muldiv_iter.sv | 141 ++++++++++++++
 tb/tb_muldiv_iter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up and fixed latency for all ops.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     a_q, b_q, ma_q, mb_q, result_q;
  logic                sa_q, sb_q, busy_q, done_q;
  logic [2*XLEN-1:0]   prod_q, prod_d;

  logic                sa_d, sb_d;
  logic [XLEN-1:0]     ma_d, mb_d, result_d;
  logic                is_div, div_ge, neg, b_zero, ovf;
  logic [XLEN:0]       mul_sum, div_sh, div_rem;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quo_s, rem_s;

  always_comb begin
    sa_d = operand_a[XLEN-1] & ~((op == 3'd3) || (op == 3'd5) || (op == 3'd7));
    sb_d = operand_b[XLEN-1] &  ((op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6));
    ma_d = sa_d ? -operand_a : operand_a;
    mb_d = sb_d ? -operand_b : operand_b;
  end

  // prod_q holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    is_div  = op_q[2];
    mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, ma_q} : '0);
    div_sh  = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_ge  = (div_sh >= {1'b0, mb_q});
    div_rem = div_ge ? (div_sh - {1'b0, mb_q}) : div_sh;
    if (is_div) prod_d = {div_rem[XLEN-1:0], prod_q[XLEN-2:0], div_ge};
    else        prod_d = {mul_sum, prod_q[XLEN-1:1]};
  end

  always_comb begin
    neg    = sa_q ^ sb_q;
    prod_s = neg ? -prod_q : prod_q;
    quo_s  = neg ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    rem_s  = sa_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
    b_zero = (b_q == '0);
    ovf    = (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1) && !op_q[0];
    case (op_q)
      3'd0:             result_d = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3: result_d = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:       result_d = quo_s;
      default:          result_d = rem_s;
    endcase
    if (is_div && b_zero)   result_d = op_q[1] ? a_q : '1;
    else if (is_div && ovf) result_d = op_q[1] ? '0 : a_q;
  end

  // The first CALC cycle (cnt_q == 0) loads the datapath; the next XLEN do the steps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      prod_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q    <= op;
            a_q     <= operand_a;
            b_q     <= operand_b;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (cnt_q == '0) begin
            prod_q <= is_div ? {{XLEN{1'b0}}, ma_q} : {{XLEN{1'b0}}, mb_q};
            cnt_q  <= cnt_q + 1'b1;
          end else begin
            prod_q <= prod_d;
            if (cnt_q == CW'(XLEN)) state_q <= FIX;
            else                    cnt_q   <= cnt_q + 1'b1;
          end
        end
        FIX: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed and random ops against an
// arithmetic reference model, latency/busy checks, ignored starts, flush and reset.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_iter #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    r  = 32'd0;
    case (o)
      3'd0: begin p = 64'(sa * sb); r = p[31:0];  end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a :
                ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Issues one op, checks busy in every cycle, exact latency, result and the return to idle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int n;
    bit busy_ok;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    tick();
    start = 1'b0; operand_a = $urandom; operand_b = $urandom; op = 3'($urandom_range(0, 7));
    n = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && n < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd34);
    chk({tag, "_busy"}, {63'd0, busy_ok & busy}, 64'd1);
    chk({tag, "_result"}, {32'd0, result}, {32'd0, ref_model(o, a, b)});
    tick();
    chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int          n, ndone;
    logic [31:0] ra, rb, held;
    logic [2:0]  ro;

    #12;
    chk("reset_outputs", {30'd0, busy, done, result}, 64'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_after_reset", {30'd0, busy, done, result}, 64'd0);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_neg");
    chk("mul_neg_const", {32'd0, result}, 64'hFFFF_FFEB);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_neg");
    run_op(3'd5, 32'd100, 32'd7, "divu");
    run_op(3'd7, 32'd100, 32'd7, "remu");
    run_op(3'd5, 32'h1234_5678, 32'd0, "divu_zero");
    run_op(3'd6, 32'h1234_5678, 32'd0, "rem_zero");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    held = result;
    repeat (3) tick();
    chk("result_held", {32'd0, result}, {32'd0, held});

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ((i % 6) == 1) rb = 32'd0;
      if ((i % 6) == 2) rb = 32'($urandom_range(1, 15));
      if ((i % 6) == 3) ra = {1'b1, 31'($urandom_range(0, 3))};
      run_op(ro, ra, rb, "random");
    end

    // Starts while busy and in the DONE cycle must be ignored.
    start = 1'b1; op = 3'd0; operand_a = 32'd1234; operand_b = 32'd5678;
    tick();
    start = 1'b0;
    n = 0;
    ndone = 0;
    while (n < 80) begin
      if (n == 5 || n == 33 || n == 34) begin
        start = 1'b1; op = 3'd5; operand_a = $urandom; operand_b = 32'd3;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
      if (done === 1'b1) ndone++;
    end
    start = 1'b0;
    chk("ignored_start_done_count", 64'(ndone), 64'd1);
    chk("ignored_start_result", {32'd0, result}, 64'd7006652);

    // Flush partway through a divide.
    held = result;
    start = 1'b1; op = 3'd4; operand_a = 32'd1000; operand_b = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle", {62'd0, busy, done}, 64'd0);
    chk("flush_result", {32'd0, result}, {32'd0, held});
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    chk("flush_no_done", 64'(ndone), 64'd0);

    flush = 1'b1; start = 1'b1;
    tick();
    flush = 1'b0; start = 1'b0;
    chk("flush_beats_start", {62'd0, busy, done}, 64'd0);
    run_op(3'd7, 32'd55, 32'd10, "after_flush");

    // Asynchronous reset in the middle of an op.
    start = 1'b1; op = 3'd1; operand_a = 32'hDEAD_BEEF; operand_b = 32'h1234_5678;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    chk("reset_mid_op", {30'd0, busy, done, result}, 64'd0);
    tick();
    reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("reset_no_done", 64'(ndone), 64'd0);
    run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
